// File: rtl/vrc6_apu_if.sv
// CPU write bus between the VRC6 mapper decode and the expansion audio block.
// The mapper drives (master); the APU only samples (slave).
interface vrc6_apu_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic        cpu_we;

    modport master (output cpu_addr, output cpu_data_in, output cpu_we);
    modport slave  (input  cpu_addr, input  cpu_data_in, input  cpu_we);
endinterface

// File: rtl/vrc6_apu.sv
// VRC6 expansion audio: two pulse channels, optional sawtooth, 6-bit mixer.
// The sawtooth channel is only built when VRC6_APU_SAW_EN is defined; without it
// $B000-$B002 writes are ignored and the mix is pulse-only.
module vrc6_apu #(
    parameter int unsigned AUDIO_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    vrc6_apu_if.slave          bus,
    output logic [AUDIO_W-1:0] audio_out
);

    // Effective divider period: >>8 takes priority over >>4.
    function automatic logic [11:0] peff(input logic [11:0] per, input logic s4, input logic s8);
        if (s8)      return per >> 8;
        else if (s4) return per >> 4;
        return per;
    endfunction

    logic [3:0] page_w;
    logic [1:0] reg_w;
    logic       pl_sel;
    logic       unused_addr;

    assign page_w      = bus.cpu_addr[15:12];
    assign reg_w       = bus.cpu_addr[1:0];
    assign pl_sel      = (page_w == 4'hA);
    assign unused_addr = ^bus.cpu_addr[11:2];

    // Register file
    logic [1:0]       pl_ign_q;
    logic [1:0][2:0]  pl_duty_q;
    logic [1:0][3:0]  pl_vol_q;
    logic [1:0][11:0] pl_per_q;
    logic [1:0]       pl_en_q;
    logic             halt_q;
    logic             shr4_q;
    logic             shr8_q;

    // Divider state
    logic [1:0][11:0] pl_cnt_q, pl_cnt_d;
    logic [1:0][3:0]  pl_step_q, pl_step_d;
    logic [1:0][3:0]  pl_out;
    logic [4:0]       saw_out;

    logic [5:0]         sum6;
    logic [AUDIO_W-1:0] audio_q, audio_d;

    // Pulse and global register writes from the mapper bus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pl_ign_q  <= '0;
            pl_duty_q <= '0;
            pl_vol_q  <= '0;
            pl_per_q  <= '0;
            pl_en_q   <= '0;
            halt_q    <= 1'b0;
            shr4_q    <= 1'b0;
            shr8_q    <= 1'b0;
        end else if (bus.cpu_we && (page_w == 4'h9 || page_w == 4'hA)) begin
            case (reg_w)
                2'd0: begin
                    pl_ign_q[pl_sel]  <= bus.cpu_data_in[7];
                    pl_duty_q[pl_sel] <= bus.cpu_data_in[6:4];
                    pl_vol_q[pl_sel]  <= bus.cpu_data_in[3:0];
                end
                2'd1: pl_per_q[pl_sel][7:0] <= bus.cpu_data_in;
                2'd2: begin
                    pl_en_q[pl_sel]         <= bus.cpu_data_in[7];
                    pl_per_q[pl_sel][11:8]  <= bus.cpu_data_in[3:0];
                end
                default: begin
                    if (!pl_sel) begin
                        halt_q <= bus.cpu_data_in[0];
                        shr4_q <= bus.cpu_data_in[1];
                        shr8_q <= bus.cpu_data_in[2];
                    end
                end
            endcase
        end
    end

    // Pulse dividers, duty steps and channel outputs
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            pl_cnt_d[i]  = pl_cnt_q[i];
            pl_step_d[i] = pl_step_q[i];
            if (!pl_en_q[i]) begin
                pl_cnt_d[i]  = peff(pl_per_q[i], shr4_q, shr8_q);
                pl_step_d[i] = '1;
            end else if (!halt_q) begin
                if (pl_cnt_q[i] == '0) begin
                    pl_cnt_d[i]  = peff(pl_per_q[i], shr4_q, shr8_q);
                    pl_step_d[i] = pl_step_q[i] - 4'd1;
                end else begin
                    pl_cnt_d[i] = pl_cnt_q[i] - 12'd1;
                end
            end
            pl_out[i] = (pl_en_q[i] && (pl_ign_q[i] || pl_step_q[i] <= {1'b0, pl_duty_q[i]}))
                        ? pl_vol_q[i] : '0;
        end
    end

    // Pulse divider state register; duty steps idle at 15
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pl_cnt_q  <= '0;
            pl_step_q <= '1;
        end else begin
            pl_cnt_q  <= pl_cnt_d;
            pl_step_q <= pl_step_d;
        end
    end

`ifdef VRC6_APU_SAW_EN
    logic [5:0]  sw_rate_q;
    logic [11:0] sw_per_q;
    logic        sw_en_q;
    logic [11:0] sw_cnt_q, sw_cnt_d;
    logic [3:0]  sw_phase_q, sw_phase_d;
    logic [7:0]  sw_acc_q, sw_acc_d;

    // Sawtooth register writes ($B003 belongs to the mapper)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_rate_q <= '0;
            sw_per_q  <= '0;
            sw_en_q   <= 1'b0;
        end else if (bus.cpu_we && page_w == 4'hB) begin
            case (reg_w)
                2'd0: sw_rate_q <= bus.cpu_data_in[5:0];
                2'd1: sw_per_q[7:0] <= bus.cpu_data_in;
                2'd2: begin
                    sw_en_q        <= bus.cpu_data_in[7];
                    sw_per_q[11:8] <= bus.cpu_data_in[3:0];
                end
                default: ;
            endcase
        end
    end

    // Sawtooth divider, 14-phase sequencer and accumulator.
    // The rate is added on the reload that moves into an odd phase, so the
    // accumulator climbs seven times (0..7R) before the phase-13 clear.
    always_comb begin
        sw_cnt_d   = sw_cnt_q;
        sw_phase_d = sw_phase_q;
        sw_acc_d   = sw_acc_q;
        if (!sw_en_q) begin
            sw_cnt_d   = peff(sw_per_q, shr4_q, shr8_q);
            sw_phase_d = '0;
            sw_acc_d   = '0;
        end else if (!halt_q) begin
            if (sw_cnt_q == '0) begin
                sw_cnt_d = peff(sw_per_q, shr4_q, shr8_q);
                if (sw_phase_q == 4'd13) begin
                    sw_phase_d = '0;
                    sw_acc_d   = '0;
                end else begin
                    sw_phase_d = sw_phase_q + 4'd1;
                    if (!sw_phase_q[0]) sw_acc_d = sw_acc_q + {2'b00, sw_rate_q};
                end
            end else begin
                sw_cnt_d = sw_cnt_q - 12'd1;
            end
        end
    end

    // Sawtooth state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_cnt_q   <= '0;
            sw_phase_q <= '0;
            sw_acc_q   <= '0;
        end else begin
            sw_cnt_q   <= sw_cnt_d;
            sw_phase_q <= sw_phase_d;
            sw_acc_q   <= sw_acc_d;
        end
    end

    assign saw_out = sw_acc_q[7:3];
`else
    assign saw_out = '0;
`endif

    // Mixer: 6-bit sum left-justified into the output word
    always_comb begin
        sum6    = 6'(pl_out[0]) + 6'(pl_out[1]) + 6'(saw_out);
        audio_d = AUDIO_W'(sum6) << (AUDIO_W - 6);
    end

    // Output sample register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) audio_q <= '0;
        else          audio_q <= audio_d;
    end

    assign audio_out = audio_q;

endmodule

// File: tb/tb_vrc6_apu.sv
// Scoreboarded directed bench for vrc6_apu.
module tb_vrc6_apu;

    localparam int unsigned AW = 16;
    localparam int unsigned SH = AW - 6;

    typedef struct {
        int          cyc;
        logic [15:0] val;
        string       tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] audio_out;
    vrc6_apu_if    bus_if ();

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q[$];

    vrc6_apu #(.AUDIO_W(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus_if),
        .audio_out (audio_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every queued expectation at its cycle's falling edge.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_tests++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: check for cycle %0d was skipped (now %0d)", e.tag, e.cyc, cyc);
            end else if (audio_out !== e.val) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: audio_out=%04h expected %04h", e.tag, cyc, audio_out, e.val);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    function automatic logic [15:0] lvl(input int s);
        return 16'(s) << SH;
    endfunction

    // Accumulator-derived saw output at phase p for rate r.
    function automatic int saw_lvl(input int r, input int p);
        return ((r * ((p + 1) / 2)) & 255) >> 3;
    endfunction

    task automatic push(input int c, input logic [15:0] v, input string tag);
        exp_t e;
        e.cyc = c;
        e.val = v;
        e.tag = tag;
        q.push_back(e);
    endtask

    // Write lands on the rising edge that makes cyc == w.
    task automatic wr(input logic [15:0] a, input logic [7:0] d, output int w);
        @(negedge clk);
        bus_if.cpu_addr    = a;
        bus_if.cpu_data_in = d;
        bus_if.cpu_we      = 1'b1;
        w = cyc + 1;
        @(negedge clk);
        bus_if.cpu_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Pulse with D=7: 8 steps low then 8 steps high, each step steplen clk.
    task automatic chk_pulse(input int w, input int steplen, input int n, input int hi, input string tag);
        for (int j = 0; j < n; j++)
            push(w + 1 + j, (((j / (8 * steplen)) % 2) == 1) ? lvl(hi) : 16'h0, tag);
    endtask

    task automatic chk_const(input int from, input int n, input logic [15:0] v, input string tag);
        for (int j = 0; j < n; j++) push(from + j, v, tag);
    endtask

    initial begin
        int w;
        int hold_lvl;
        bus_if.cpu_addr    = '0;
        bus_if.cpu_data_in = '0;
        bus_if.cpu_we      = 1'b0;

        // 1: idle after reset, then writes outside $9000-$BFFF / to $B003
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk_const(cyc + 1, 100, 16'h0, "idle");
        repeat (100) @(negedge clk);
        wr(16'hC000, 8'h8F, w);
        wr(16'hC002, 8'h80, w);
        wr(16'h8000, 8'h8F, w);
        wr(16'h8002, 8'h80, w);
        wr(16'hB003, 8'hFF, w);
        chk_const(w + 1, 20, 16'h0, "ignored_addr");
        repeat (21) @(negedge clk);

        // 2: 50% pulse, period 3, then halt freezes the level
        do_reset();
        wr(16'h9000, 8'h7F, w);
        wr(16'h9001, 8'h03, w);
        wr(16'h9002, 8'h80, w);
        chk_pulse(w, 4, 128, 15, "p1_duty50");
        begin
            int w3;
            w3 = w;
            repeat (128) @(negedge clk);
            wr(16'h9003, 8'h01, w);
            hold_lvl = (((w - w3) / 32) % 2 == 1) ? 15 : 0;
        end
        chk_const(w + 1, 40, lvl(hold_lvl), "p1_halt_hold");
        repeat (41) @(negedge clk);

        // 3: ignore-duty on pulse 2 at period 0, halt, then disable
        do_reset();
        wr(16'hA000, 8'h8A, w);
        wr(16'hA002, 8'h80, w);
        chk_const(w + 1, 20, lvl(10), "p2_const");
        repeat (20) @(negedge clk);
        wr(16'h9003, 8'h01, w);
        chk_const(w + 1, 10, lvl(10), "p2_halt");
        repeat (10) @(negedge clk);
        wr(16'hA002, 8'h00, w);
        chk_const(w + 1, 10, 16'h0, "p2_disable");
        repeat (11) @(negedge clk);

        // 4: sawtooth rate 8, period 0
        do_reset();
        wr(16'hB000, 8'h08, w);
        wr(16'hB001, 8'h00, w);
        wr(16'hB002, 8'h80, w);
        for (int j = 0; j < 42; j++) begin
`ifdef VRC6_APU_SAW_EN
            push(w + 1 + j, lvl(saw_lvl(8, j % 14)), "saw_r8");
`else
            push(w + 1 + j, 16'h0, "saw_absent");
`endif
        end
        repeat (43) @(negedge clk);

        // 5: period $0FF with >>4 gives Peff=15; >>8 wins when both set
        do_reset();
        wr(16'h9003, 8'h02, w);
        wr(16'h9000, 8'h7F, w);
        wr(16'h9001, 8'hFF, w);
        wr(16'h9002, 8'h80, w);
        chk_pulse(w, 16, 256, 15, "p1_shr4");
        repeat (257) @(negedge clk);
        wr(16'h9002, 8'h00, w);
        wr(16'h9003, 8'h06, w);
        wr(16'h9002, 8'h80, w);
        chk_pulse(w, 1, 40, 15, "p1_shr8_prio");
        repeat (41) @(negedge clk);

        // 6: all channels at maximum, then asynchronous reset
        do_reset();
        wr(16'h9000, 8'h8F, w);
        wr(16'h9002, 8'h80, w);
        wr(16'hA000, 8'h8F, w);
        wr(16'hA002, 8'h80, w);
        wr(16'hB000, 8'h3F, w);
        wr(16'hB002, 8'h80, w);
        for (int j = 0; j < 28; j++) begin
`ifdef VRC6_APU_SAW_EN
            push(w + 1 + j, lvl(30 + saw_lvl(63, j % 14)), "mix_max");
`else
            push(w + 1 + j, lvl(30), "mix_pulses");
`endif
        end
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        push(cyc, 16'h0, "async_reset");
        chk_const(cyc + 1, 3, 16'h0, "in_reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk_const(cyc + 1, 10, 16'h0, "after_reset");
        repeat (11) @(negedge clk);

        // Drain with a bounded wait
        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            $display("FAIL drain: %0d expectations never checked, required 0", q.size());
            n_tests += q.size();
            n_fail  += q.size();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
